// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, captures {pc, instr} into an in-order queue,
// presents the queue head to decode via valid/ready, and flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   q_instr [DEPTH];
  logic          pop;
  logic          fetch;

  assign PC       = pc;
  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;
  // A pop frees the slot being written this same edge, so a full queue can still fetch.
  assign fetch    = !redirect_valid & ((count < CW'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc & ~32'h0000_0003;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fetch) begin
        pc     <= pc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({fetch, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; id_valid gates everything read from it.
  always_ff @(posedge clk) begin
    if (fetch) begin
      q_pc[wr_ptr]    <= pc;
      q_instr[wr_ptr] <= Instr;
    end
  end

  always_comb begin
    id_instr = '0;
    id_pc    = '0;
    if (id_valid) begin
      id_instr = q_instr[rd_ptr];
      id_pc    = q_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for stream/backpressure/redirect,
// plus hand sequences for async reset mid-operation and PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic        rst_w_n = 1'b0;
  logic [31:0] w_pc_out;
  logic [31:0] w_instr;
  logic        w_id_valid;
  logic [31:0] w_id_instr;
  logic [31:0] w_id_pc;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0000_0083 + (a >> 2);
  endfunction

  assign instr   = mem(pc_out);
  assign w_instr = mem(w_pc_out);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .PC(pc_out), .Instr(instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_w_n), .PC(w_pc_out), .Instr(w_instr),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(w_id_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc)
  );

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        v;
    logic [31:0] pc;
    logic [31:0] idpc;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic v, input logic [31:0] pc, input logic [31:0] idpc,
                     input logic [31:0] ins);
    vec_t t;
    t.rdy = rdy; t.redir = redir; t.rpc = rpc;
    t.v = v; t.pc = pc; t.idpc = idpc; t.ins = ins;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // cycle-indexed: inputs driven in the cycle, outputs expected in that cycle
    add(0,0,0, 0,32'h00,32'h00,32'h00);
    add(0,0,0, 1,32'h04,32'h00,32'h83);
    add(0,0,0, 1,32'h08,32'h00,32'h83);
    add(0,0,0, 1,32'h0C,32'h00,32'h83);
    for (int k = 0; k < 6; k++) add(0,0,0, 1,32'h10,32'h00,32'h83);
    add(1,0,0, 1,32'h10,32'h00,32'h83);
    add(0,0,0, 1,32'h14,32'h04,32'h84);
    add(0,0,0, 1,32'h14,32'h04,32'h84);
    add(1,0,0, 1,32'h14,32'h04,32'h84);
    add(1,0,0, 1,32'h18,32'h08,32'h85);
    add(1,0,0, 1,32'h1C,32'h0C,32'h86);
    add(1,0,0, 1,32'h20,32'h10,32'h87);
    add(1,0,0, 1,32'h24,32'h14,32'h88);
    add(1,1,32'h102, 1,32'h28,32'h18,32'h89);
    add(1,0,0, 0,32'h100,32'h000,32'h00);
    add(1,0,0, 1,32'h104,32'h100,32'hC3);
    add(1,0,0, 1,32'h108,32'h104,32'hC4);
    add(1,1,32'h200, 1,32'h10C,32'h108,32'hC5);
    add(1,1,32'h303, 0,32'h200,32'h000,32'h00);
    add(1,0,0, 0,32'h300,32'h000,32'h00);
    add(1,0,0, 1,32'h304,32'h300,32'h143);
    add(0,0,0, 1,32'h308,32'h304,32'h144);
    add(0,0,0, 1,32'h30C,32'h304,32'h144);

    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, id_valid}, 32'h0);
    check("reset_pc", pc_out, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      id_ready       = vecs[i].rdy;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].v});
      check($sformatf("v%0d_PC", i), pc_out, vecs[i].pc);
      check($sformatf("v%0d_id_pc", i), id_pc, vecs[i].idpc);
      check($sformatf("v%0d_id_instr", i), id_instr, vecs[i].ins);
      @(negedge clk);
    end

    // Queue holds 304, 308, 30C here; reset must act without a clock edge.
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    check("pre_async_valid", {31'b0, id_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_valid", {31'b0, id_valid}, 32'h0);
    check("async_id_pc", id_pc, 32'h0);
    check("async_id_instr", id_instr, 32'h0);
    check("async_PC", pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    #1;
    check("resume0_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk);
    check("resume1_valid", {31'b0, id_valid}, 32'h1);
    check("resume1_id_pc", id_pc, 32'h0);
    check("resume1_PC", pc_out, 32'h4);
    @(negedge clk);
    check("resume2_id_pc", id_pc, 32'h4);
    check("resume2_id_instr", id_instr, 32'h84);

    // Wrap instance: streaming across the top of the address space.
    rst_w_n = 1'b1;
    #1;
    check("wrap0_valid", {31'b0, w_id_valid}, 32'h0);
    check("wrap0_PC", w_pc_out, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap1_id_pc", w_id_pc, 32'hFFFF_FFF8);
    check("wrap1_id_instr", w_id_instr, 32'h4000_0081);
    @(negedge clk);
    check("wrap2_id_pc", w_id_pc, 32'hFFFF_FFFC);
    check("wrap2_PC", w_pc_out, 32'h0000_0000);
    @(negedge clk);
    check("wrap3_id_pc", w_id_pc, 32'h0000_0000);
    check("wrap3_id_instr", w_id_instr, 32'h0000_0083);
    @(negedge clk);
    check("wrap4_id_pc", w_id_pc, 32'h0000_0004);
    check("wrap4_valid", {31'b0, w_id_valid}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
